mr_wb_ram: RTL
==============

# mr_wb_ram

Pipelined Wishbone B4 slave backed by a synchronous word-addressed RAM; the responder on the other end of the load/store unit's data bus. It accepts one request per cycle, commits writes with byte-lane selects, and returns acks (or errors for out-of-range addresses) a fixed number of cycles after acceptance. It serves as on-chip data memory and as the bus-compliance target for the memory stage.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in XLEN-bit words; must be a power of two.
- `BASE_WORD`, default 0: word address (`addr_i` units) of RAM word 0.
- `LATENCY`, default 1: cycles from acceptance to ack/err; legal range 1..4.
- `INIT_FILE`, default "": hex file loaded with `$readmemh` at elaboration; empty string means no load.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cyc_i`  in  1  bus cycle active.
- `stb_i`  in  1  request strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  `XLEN-XLEN_GRAN`  word address (`[XLEN-1:XLEN_GRAN]`).
- `sel_i`  in  `XLEN/8`  byte-lane enables.
- `dat_i`  in  `XLEN`  write data.
- `ack_o`  out  1  request completed.
- `err_o`  out  1  request failed because the address is out of range.
- `stall_o`  out  1  request not accepted this cycle.
- `dat_o`  out  `XLEN`  read data; valid with `ack_o`.

## Operation
- **Acceptance.** A request is accepted in a cycle where `cyc_i & stb_i & !stall_o`.
- **Decode.**
  - `idx = addr_i - BASE_WORD`, computed in `XLEN-XLEN_GRAN` bits with unsigned wrap.
  - The address is in range iff `idx < DEPTH_WORDS`.
- **Write.** An in-range write updates byte lane b in the acceptance cycle's clock edge iff `sel_i[b]`.
  - `sel_i == 0`: no change, but the request still acks.
  - Out-of-range writes change nothing.
- **Read.** RAM is read at acceptance using the pre-edge contents.
  - A write accepted in cycle N is visible to a read accepted in N+1 or later.
  - `sel_i` is ignored for reads; the full word is returned.
- **Response pipeline.** An LATENCY-deep shift register of {valid, is_err, rdata}.
  - Stage 0 is loaded at acceptance.
  - The last stage drives `ack_o = valid & !is_err`, `err_o = valid & is_err`, and `dat_o`.
- **Output values.**
  - `dat_o` is 0 for writes and errors.
  - `dat_o` holds its last value when `ack_o` is low.
- **Bus-cycle abort.** If `cyc_i` drops, all pipeline valid bits are cleared on that edge.
  - No ack/err is emitted while `cyc_i` is low.
  - Writes already accepted remain committed.
- **Ordering.** Responses return in acceptance order; at most one of `ack_o`/`err_o` is high per cycle.

## Timing
- **Reset values.** `rst` clears `ack_o`, `err_o`, `stall_o`, `dat_o` and all pipeline valid bits. RAM contents are not reset.
- **Latency.** Accept at cycle N, then ack/err at cycle N+LATENCY.
- **Throughput.** One request per cycle; at most LATENCY requests outstanding.
- **`stall_o`.** A registered output; 0 at all times unless `MR_WB_RAM_STALL_INJECT_EN` is defined.
- **`stb_i` without `cyc_i`.** Ignored.
- **Reset mid-operation.** `rst` in cycle N suppresses acceptance in cycle N and discards all in-flight responses; the first ack is possible at N+1+LATENCY.
- **Simultaneous events.** If `cyc_i` falls in the same cycle a response reaches the last stage, that response is dropped.

## Configuration
- **Macro:** `MR_WB_RAM_STALL_INJECT_EN`.
- **Defined.**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - Next-cycle `stall_o = lfsr[0] & lfsr[1]`, giving about 25% stall.
  - Requests presented while stalled are not accepted; the master must hold them.
  - Reset forces `stall_o` to 0 for the first cycle after reset.
- **Not defined.** No LFSR exists and `stall_o` is constant 0.

## Test plan
- **Single write/read:** LATENCY=1, write `addr_i=5`, `dat_i=32'hDEADBEEF`, `sel_i=4'hF` at cycle 0, then read addr 5 at cycle 1 → ack at cycles 1 and 2; read `dat_o=32'hDEADBEEF`.
- **Byte lanes:** word 7 holds 32'h11223344; write `dat_i=32'hAABBCCDD`, `sel_i=4'b0101`, then read → `dat_o=32'h11BB33DD`.
- **Pipelining:** LATENCY=3, four back-to-back reads of words 0..3 preloaded with 0..3 → acks on four consecutive cycles starting 3 cycles after the first acceptance, `dat_o` = 0,1,2,3 in order.
- **Out-of-range:** `BASE_WORD=16`, DEPTH_WORDS=1024, write to word 8 and read word 1040 → `err_o` for both with `ack_o` low and no RAM change; a subsequent read of word 16 returns an ack.
- **Abort:** LATENCY=4, two reads accepted, then `cyc_i` dropped one cycle later → no ack/err at any later cycle; a new cycle behaves normally.
- **Stall injection:** with the macro defined, 200 random requests from a compliant master → every accepted request gets exactly one ack or err, and none is accepted while `stall_o` is high.

Source files
------------

// File: rtl/mr_wb_ram_if.sv
// Pipelined Wishbone B4 data-bus bundle between a load/store master and
// the mr_wb_ram responder. Member names follow the slave's point of view.
interface mr_wb_ram_if #(
  parameter int XLEN      = 32,
  parameter int XLEN_GRAN = 2
);
  logic                   cyc_i;
  logic                   stb_i;
  logic                   we_i;
  logic [XLEN-1:XLEN_GRAN] addr_i;
  logic [XLEN/8-1:0]      sel_i;
  logic [XLEN-1:0]        dat_i;
  logic                   ack_o;
  logic                   err_o;
  logic                   stall_o;
  logic [XLEN-1:0]        dat_o;

  modport master (
    output cyc_i, stb_i, we_i, addr_i, sel_i, dat_i,
    input  ack_o, err_o, stall_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, sel_i, dat_i,
    output ack_o, err_o, stall_o, dat_o
  );
endinterface

// File: rtl/mr_wb_ram.sv
// mr_wb_ram: pipelined Wishbone B4 slave in front of a word-addressed RAM.
// One request per cycle; ack/err returns LATENCY (1..4) cycles after
// acceptance, in order. Out-of-range addresses answer with err and leave
// the RAM untouched. Dropping cyc_i kills every in-flight response.
// Optional feature macro: MR_WB_RAM_STALL_INJECT_EN adds LFSR-driven
// pseudo-random stalls (about 25%); without it stall_o is constant 0.
module mr_wb_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    BASE_WORD   = 0,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = "",
  parameter int    XLEN        = 32,
  parameter int    XLEN_GRAN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  mr_wb_ram_if.slave bus
);

  localparam int AW = XLEN - XLEN_GRAN;
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]    mem_q [DEPTH_WORDS];

  logic [AW-1:0]      idx_s;
  logic               in_range_s;
  logic               accept_s;
  logic               wr_en_s;
  logic [XLEN-1:0]    rd_word_s;

  // Response pipeline: stage 0 is loaded at acceptance, stage LATENCY-1 answers.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] perr_q, perr_d;
  logic [XLEN-1:0]    pdat_q [LATENCY];
  logic [XLEN-1:0]    pdat_d [LATENCY];

  logic               stall_q, stall_d;
  logic [XLEN-1:0]    dat_hold_q, dat_hold_d;
  logic               ack_s, err_s;

  // Decode the request and compute the next response-pipeline contents.
  always_comb begin
    idx_s      = bus.addr_i - AW'(BASE_WORD);
    in_range_s = ({1'b0, idx_s} < (AW+1)'(DEPTH_WORDS));
    accept_s   = bus.cyc_i & bus.stb_i & ~stall_q & ~rst;
    wr_en_s    = accept_s & bus.we_i & in_range_s;
    rd_word_s  = mem_q[idx_s[IW-1:0]];
    vld_d      = {LATENCY{1'b0}};
    perr_d     = {LATENCY{1'b0}};
    for (int i = 0; i < LATENCY; i++) begin
      pdat_d[i] = {XLEN{1'b0}};
    end
    if (bus.cyc_i) begin
      vld_d[0]  = accept_s;
      perr_d[0] = ~in_range_s;
      // Writes and errors carry zero data so dat_o reads 0 for them.
      pdat_d[0] = (bus.we_i | ~in_range_s) ? {XLEN{1'b0}} : rd_word_s;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1];
        perr_d[i] = perr_q[i-1];
        pdat_d[i] = pdat_q[i-1];
      end
    end else begin
      // Bus cycle aborted: everything in flight is discarded on this edge.
      vld_d = {LATENCY{1'b0}};
    end
  end

  // Commit in-range writes lane by lane; reads in the same cycle see old data.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.sel_i[b]) begin
          mem_q[idx_s[IW-1:0]][b*8 +: 8] <= bus.dat_i[b*8 +: 8];
        end
      end
    end
  end

  // Advance the response pipeline and the dat_o hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= {LATENCY{1'b0}};
      dat_hold_q <= {XLEN{1'b0}};
    end else begin
      vld_q      <= vld_d;
      dat_hold_q <= dat_hold_d;
    end
    perr_q <= perr_d;
    for (int i = 0; i < LATENCY; i++) begin
      pdat_q[i] <= pdat_d[i];
    end
  end

`ifdef MR_WB_RAM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Step the x^16+x^14+x^13+x^11 Fibonacci LFSR and derive next-cycle stall.
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_d = lfsr_q[0] & lfsr_q[1];
  end

  // Stall state registers; stall_o is forced low for the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= 16'hACE1;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end
`else
  assign stall_d = 1'b0;

  // Stall register kept so stall_o stays a registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  // A response is suppressed if cyc_i is low in the cycle it would appear.
  assign ack_s      = vld_q[LATENCY-1] & ~perr_q[LATENCY-1] & bus.cyc_i;
  assign err_s      = vld_q[LATENCY-1] &  perr_q[LATENCY-1] & bus.cyc_i;
  assign dat_hold_d = (ack_s | err_s) ? pdat_q[LATENCY-1] : dat_hold_q;

  assign bus.ack_o   = ack_s;
  assign bus.err_o   = err_s;
  assign bus.dat_o   = dat_hold_d;
  assign bus.stall_o = stall_q;

endmodule
